ldpc_dec_sched: RTL and testbench
=================================

Name: ldpc_dec_sched

Overview:
Multi-channel frame scheduler in front of a single shared LDPC decoder.
- Round-robin arbitrates whole frames from pNCH independent LLR sources into the decoder input port.
- Enforces a fixed frame length by padding short frames and dropping overrun words.
- Stamps each frame's decoder tag with the source channel number, then demultiplexes decoder output strobes back to that channel.

Parameters:
pNCH, 4, number of source channels (2..8)
pCH_W, $clog2(pNCH), channel-index width inside the decoder tag
pLLR_W, 5, LLR bitwidth
pLLR_BY_CYCLE, 2, LLRs per word
pFRAME_WORDS, 32, words per codeword (pN*.../pLLR_BY_CYCLE), at least 2
pUTAG_W, 2, user tag width per channel
pTAG_W, pCH_W+pUTAG_W, decoder tag width

Ports:
iclk  in  1  clock
ireset  in  1  asynchronous, active-low reset
iclkena  in  1  clock enable; all state holds when low
ich_sop  in  pNCH  per-channel start of frame
ich_eop  in  pNCH  per-channel end of frame
ich_val  in  pNCH  per-channel word valid
ich_LLR  in  pNCH*pLLR_BY_CYCLE*pLLR_W  packed LLR words, channel 0 in the LSBs
ich_niter  in  pNCH*8  per-channel iteration count
ich_fmode  in  pNCH  per-channel decoder fmode
ich_utag  in  pNCH*pUTAG_W  per-channel user tag
och_rdy  out  pNCH  per-channel accept strobe
dec_ordy  in  1  decoder ready for a new frame
dec_isop/dec_ieop/dec_ival  out  1 each  decoder input strobes
dec_iLLR  out  pLLR_BY_CYCLE*pLLR_W  decoder input word
dec_iNiter  out  8  iteration count, valid with dec_isop
dec_ifmode  out  1  fmode, valid with dec_isop
dec_itag  out  pTAG_W  {channel, utag}, valid with dec_isop
dec_oval/dec_oeop  in  1 each  decoder output strobes
dec_otag  in  pTAG_W  decoder output tag
och_oval  out  pNCH  demuxed output valid
och_oeop  out  pNCH  demuxed output eop
ostat_pad  out  pNCH  sticky: a short frame was padded
ostat_ovf  out  pNCH  sticky: a long frame was truncated

Behaviour:
Reset: all outputs 0, state IDLE, RR pointer 0, word counter 0, sticky flags 0.

Request:
- Channel i requests when ich_val[i] & ich_sop[i].
- The source holds its sop word until och_rdy[i].

States:
- IDLE:
  - If dec_ordy and any request: grant the first requesting channel at or after the pointer, wrapping.
  - Latch niter, fmode and utag for that channel.
  - Pointer <= grant+1 mod pNCH.
  - Go to PASS.
- PASS:
  - och_rdy[g]=1 for the whole state; all other och_rdy bits are 0.
  - Each ich_val[g] word is registered to the decoder with 1-cycle latency; word counter cnt increments.
  - The first word drives dec_isop with dec_iNiter, dec_ifmode and dec_itag={g,utag}.
  - Gaps in ich_val are passed through as gaps.
  - Source eop with cnt==pFRAME_WORDS-1: dec_ieop on that word, go to IDLE.
  - Source eop with cnt<pFRAME_WORDS-1: that word is forwarded without dec_ieop; set ostat_pad[g]; go to PAD.
  - Word at cnt==pFRAME_WORDS-1 without source eop: forward it with dec_ieop; set ostat_ovf[g]; go to DROP.
- PAD:
  - och_rdy all 0.
  - One all-zero LLR word per cycle (dec_ival=1) until pFRAME_WORDS words are sent.
  - The last pad word carries dec_ieop; go to IDLE.
- DROP:
  - och_rdy[g] stays 1.
  - Words are discarded with no dec_ival.
  - Go to IDLE on source eop.

Counter and boundaries:
- cnt is $clog2(pFRAME_WORDS) bits and is cleared on entry to IDLE.
- Sop seen in PASS, i.e. a new frame without eop, is treated as a data word; no restart.
- A frame with sop&eop on the same word is padded to full length.
- ich_sop/ich_eop on non-granted channels are ignored.
- A new frame is never started with dec_ordy low; dec_ordy is sampled only in IDLE.

Output demux:
- och_oval[c] = dec_oval & (dec_otag[pTAG_W-1 -: pCH_W]==c), combinational.
- och_oeop is built the same way.
- Data, err and decfail are taken directly from the decoder by consumers.

Other rules:
- iclkena low freezes all state and registered outputs, including mid-frame.
- Reset mid-frame aborts immediately, with no eop issued to the decoder.
- Sticky flags clear only on reset.

Test Plan:
1. Only ch2 requests, niter=10, utag=1, 32 words → one dec_isop with dec_iNiter=10, dec_itag={2'd2,2'd1}; 32 dec_ival; dec_ieop on the 32nd; och_rdy=4'b0100 for the frame only.
2. All 4 channels request continuously, dec_ordy=1, pointer 0 → frames granted in order 0,1,2,3,0; at most one och_rdy bit high at any time.
3. ch1 eop at word 20 → 20 source words, then 12 zero words; dec_ieop on word 32; ostat_pad=4'b0010; next grant only after that.
4. ch3 sends 40 words, eop on the 40th → dec_ieop on word 32; words 33..40 produce no dec_ival; och_rdy[3] high through word 40; ostat_ovf=4'b1000.
5. dec_ordy=0 with requests pending for 50 cycles → no grant, no dec_isop; grant within 2 cycles after dec_ordy rises.
6. dec_oval with dec_otag channel field = 3 → och_oval=4'b1000. Also: iclkena low for 5 cycles mid-PASS → frame resumes intact. Also: ireset asserted mid-PASS → all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/ldpc_dec_sched_if.sv
// Decoder-side bus of the LDPC frame scheduler: frame input strobes/data towards the
// decoder, plus its ready flag and output strobes/tag coming back.
interface ldpc_dec_sched_if #(
  parameter int pLLR_W        = 5,
  parameter int pLLR_BY_CYCLE = 2,
  parameter int pTAG_W        = 4
);
  logic                              dec_ordy;
  logic                              dec_isop;
  logic                              dec_ieop;
  logic                              dec_ival;
  logic [pLLR_BY_CYCLE*pLLR_W-1:0]   dec_iLLR;
  logic [7:0]                        dec_iNiter;
  logic                              dec_ifmode;
  logic [pTAG_W-1:0]                 dec_itag;
  logic                              dec_oval;
  logic                              dec_oeop;
  logic [pTAG_W-1:0]                 dec_otag;

  modport master (
    input  dec_ordy, dec_oval, dec_oeop, dec_otag,
    output dec_isop, dec_ieop, dec_ival, dec_iLLR, dec_iNiter, dec_ifmode, dec_itag
  );

  modport slave (
    output dec_ordy, dec_oval, dec_oeop, dec_otag,
    input  dec_isop, dec_ieop, dec_ival, dec_iLLR, dec_iNiter, dec_ifmode, dec_itag
  );
endinterface

// File: rtl/ldpc_dec_sched.sv
// Round-robin whole-frame scheduler feeding one shared LDPC decoder: fixes frame length
// (pad short / drop overrun), tags frames with their channel and demuxes decoder outputs.
module ldpc_dec_sched #(
  parameter int pNCH          = 4,
  parameter int pCH_W         = $clog2(pNCH),
  parameter int pLLR_W        = 5,
  parameter int pLLR_BY_CYCLE = 2,
  parameter int pFRAME_WORDS  = 32,
  parameter int pUTAG_W       = 2,
  parameter int pTAG_W        = pCH_W + pUTAG_W
) (
  input  logic                                iclk,
  input  logic                                ireset,
  input  logic                                iclkena,
  input  logic [pNCH-1:0]                     ich_sop,
  input  logic [pNCH-1:0]                     ich_eop,
  input  logic [pNCH-1:0]                     ich_val,
  input  logic [pNCH*pLLR_BY_CYCLE*pLLR_W-1:0] ich_LLR,
  input  logic [pNCH*8-1:0]                   ich_niter,
  input  logic [pNCH-1:0]                     ich_fmode,
  input  logic [pNCH*pUTAG_W-1:0]             ich_utag,
  output logic [pNCH-1:0]                     och_rdy,
  ldpc_dec_sched_if.master                    dec,
  output logic [pNCH-1:0]                     och_oval,
  output logic [pNCH-1:0]                     och_oeop,
  output logic [pNCH-1:0]                     ostat_pad,
  output logic [pNCH-1:0]                     ostat_ovf
);

  localparam int WORD_W = pLLR_BY_CYCLE * pLLR_W;
  localparam int CNT_W  = $clog2(pFRAME_WORDS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(pFRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, PASS, PAD, DROP} state_t;

  state_t               state_reg;
  logic [pCH_W-1:0]     ptr_reg;
  logic [pCH_W-1:0]     gnt_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [7:0]           niter_reg;
  logic                 fmode_reg;
  logic [pUTAG_W-1:0]   utag_reg;
  logic [pNCH-1:0]      rdy_reg;
  logic [pNCH-1:0]      pad_reg;
  logic [pNCH-1:0]      ovf_reg;
  logic                 isop_reg;
  logic                 ieop_reg;
  logic                 ival_reg;
  logic [WORD_W-1:0]    llr_reg;
  logic [7:0]           initer_reg;
  logic                 ifmode_reg;
  logic [pTAG_W-1:0]    itag_reg;

  logic [pNCH-1:0]      req;
  logic                 gnt_any;
  logic [pCH_W-1:0]     gnt_idx;
  logic [pCH_W-1:0]     ptr_next;
  logic                 sel_val;
  logic                 sel_eop;
  logic [WORD_W-1:0]    sel_llr;
  logic [pCH_W-1:0]     otag_ch;

  assign req = ich_val & ich_sop;

  // Scan from the far end back towards the pointer so the nearest requester wins last.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = pNCH - 1; k >= 0; k--) begin
      if (req[(int'(ptr_reg) + k) % pNCH]) begin
        gnt_any = 1'b1;
        gnt_idx = pCH_W'((int'(ptr_reg) + k) % pNCH);
      end
    end
  end

  assign ptr_next = (gnt_idx == pCH_W'(pNCH - 1)) ? '0 : gnt_idx + 1'b1;
  assign sel_val  = ich_val[gnt_reg];
  assign sel_eop  = ich_eop[gnt_reg];
  assign sel_llr  = ich_LLR[int'(gnt_reg)*WORD_W +: WORD_W];

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      state_reg  <= IDLE;
      ptr_reg    <= '0;
      gnt_reg    <= '0;
      cnt_reg    <= '0;
      niter_reg  <= '0;
      fmode_reg  <= 1'b0;
      utag_reg   <= '0;
      rdy_reg    <= '0;
      pad_reg    <= '0;
      ovf_reg    <= '0;
      isop_reg   <= 1'b0;
      ieop_reg   <= 1'b0;
      ival_reg   <= 1'b0;
      llr_reg    <= '0;
      initer_reg <= '0;
      ifmode_reg <= 1'b0;
      itag_reg   <= '0;
    end else if (iclkena) begin
      isop_reg <= 1'b0;
      ieop_reg <= 1'b0;
      ival_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          if (dec.dec_ordy && gnt_any) begin
            gnt_reg   <= gnt_idx;
            ptr_reg   <= ptr_next;
            niter_reg <= ich_niter[int'(gnt_idx)*8 +: 8];
            fmode_reg <= ich_fmode[gnt_idx];
            utag_reg  <= ich_utag[int'(gnt_idx)*pUTAG_W +: pUTAG_W];
            rdy_reg   <= pNCH'(1) << gnt_idx;
            state_reg <= PASS;
          end
        end
        PASS: begin
          if (sel_val) begin
            ival_reg <= 1'b1;
            llr_reg  <= sel_llr;
            cnt_reg  <= cnt_reg + 1'b1;
            if (cnt_reg == '0) begin
              isop_reg   <= 1'b1;
              initer_reg <= niter_reg;
              ifmode_reg <= fmode_reg;
              itag_reg   <= {gnt_reg, utag_reg};
            end
            if (cnt_reg == LAST_CNT) begin
              ieop_reg <= 1'b1;
              cnt_reg  <= '0;
              if (sel_eop) begin
                rdy_reg   <= '0;
                state_reg <= IDLE;
              end else begin
                // Keep accepting the overrun tail so the source can reach its eop.
                ovf_reg[gnt_reg] <= 1'b1;
                state_reg        <= DROP;
              end
            end else if (sel_eop) begin
              pad_reg[gnt_reg] <= 1'b1;
              rdy_reg          <= '0;
              state_reg        <= PAD;
            end
          end
        end
        PAD: begin
          ival_reg <= 1'b1;
          llr_reg  <= '0;
          cnt_reg  <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            ieop_reg  <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end
        end
        DROP: begin
          if (sel_val && sel_eop) begin
            rdy_reg   <= '0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign och_rdy        = rdy_reg;
  assign ostat_pad      = pad_reg;
  assign ostat_ovf      = ovf_reg;
  assign dec.dec_isop   = isop_reg;
  assign dec.dec_ieop   = ieop_reg;
  assign dec.dec_ival   = ival_reg;
  assign dec.dec_iLLR   = llr_reg;
  assign dec.dec_iNiter = initer_reg;
  assign dec.dec_ifmode = ifmode_reg;
  assign dec.dec_itag   = itag_reg;

  assign otag_ch = dec.dec_otag[pTAG_W-1 -: pCH_W];

  generate
    for (genvar gi = 0; gi < pNCH; gi++) begin : g_demux
      assign och_oval[gi] = dec.dec_oval & (otag_ch == pCH_W'(gi));
      assign och_oeop[gi] = dec.dec_oeop & (otag_ch == pCH_W'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_ldpc_dec_sched.sv
// Bench for ldpc_dec_sched: queued per-channel sources with random data/gaps, a frame-level
// scoreboard of expected decoder frames, and directed steps for each scheduling rule.
module tb_ldpc_dec_sched;
  localparam int NCH = 4, FW = 32, LW = 5, LBC = 2, WW = LW*LBC, UW = 2, TW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clkena = 1'b1;
  logic [NCH-1:0]    ich_sop, ich_eop, ich_val, ich_fmode;
  logic [NCH*WW-1:0] ich_LLR;
  logic [NCH*8-1:0]  ich_niter;
  logic [NCH*UW-1:0] ich_utag;
  logic [NCH-1:0]    och_rdy, och_oval, och_oeop, ostat_pad, ostat_ovf;

  ldpc_dec_sched_if #(.pLLR_W(LW), .pLLR_BY_CYCLE(LBC), .pTAG_W(TW)) dif ();

  ldpc_dec_sched #(.pNCH(NCH), .pLLR_W(LW), .pLLR_BY_CYCLE(LBC), .pFRAME_WORDS(FW),
                   .pUTAG_W(UW)) dut (
    .iclk(clk), .ireset(rst_n), .iclkena(clkena),
    .ich_sop(ich_sop), .ich_eop(ich_eop), .ich_val(ich_val), .ich_LLR(ich_LLR),
    .ich_niter(ich_niter), .ich_fmode(ich_fmode), .ich_utag(ich_utag),
    .och_rdy(och_rdy), .dec(dif.master),
    .och_oval(och_oval), .och_oeop(och_oeop), .ostat_pad(ostat_pad), .ostat_ovf(ostat_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic sop; logic eop; logic [WW-1:0] data; logic [7:0] niter; logic fmode; logic [UW-1:0] utag;
  } sw_t;
  typedef struct packed {
    logic [1:0] ch; logic [7:0] niter; logic fmode; logic [UW-1:0] utag; logic [FW*WW-1:0] words;
  } ef_t;

  sw_t  srcq [NCH][$];
  ef_t  expq [$];
  int   obs_order [$];
  int   checks = 0, errors = 0;
  logic [NCH-1:0] exp_pad = '0, exp_ovf = '0, rdy_seen = '0;
  logic in_frame = 1'b0, last_en = 1'b0;
  logic [FW*WW-1:0] mon_words;
  int   mon_n = 0, isop_cnt = 0, stray_cnt = 0, rdy_multi = 0;
  logic [TW-1:0] mon_tag;
  logic [7:0] mon_niter;
  logic mon_fmode;
  bit   gaps_en = 1'b1, rand_ordy = 1'b0;

  task automatic check(input string tag, input logic [FW*WW-1:0] obs, input logic [FW*WW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input int ch, input int len, input logic [7:0] niter,
                           input logic fm, input logic [UW-1:0] ut);
    ef_t e;
    sw_t w;
    e = '0;
    e.ch = 2'(ch); e.niter = niter; e.fmode = fm; e.utag = ut;
    for (int k = 0; k < len; k++) begin
      w.sop = (k == 0); w.eop = (k == len - 1); w.data = WW'($urandom);
      w.niter = niter; w.fmode = fm; w.utag = ut;
      srcq[ch].push_back(w);
      if (k < FW) e.words[k*WW +: WW] = w.data;
    end
    expq.push_back(e);
    if (len < FW) exp_pad[ch] = 1'b1;
    if (len > FW) exp_ovf[ch] = 1'b1;
  endtask

  task automatic drive();
    sw_t w;
    for (int ch = 0; ch < NCH; ch++) begin
      if (srcq[ch].size() > 0) begin
        w = srcq[ch][0];
        ich_val[ch] = w.sop ? 1'b1 : (!gaps_en || $urandom_range(0, 3) != 0);
        ich_sop[ch] = w.sop;
        ich_eop[ch] = w.eop;
        ich_LLR[ch*WW +: WW] = w.data;
        ich_niter[ch*8 +: 8] = w.niter;
        ich_fmode[ch] = w.fmode;
        ich_utag[ch*UW +: UW] = w.utag;
      end else begin
        ich_val[ch] = 1'b0; ich_sop[ch] = 1'b0; ich_eop[ch] = 1'b0;
      end
    end
    if (rand_ordy) dif.dec_ordy = 1'($urandom_range(0, 1));
  endtask

  task automatic check_frame();
    int ch, idx;
    ef_t e;
    ch = int'(mon_tag[TW-1 -: 2]);
    idx = -1;
    for (int k = 0; k < expq.size(); k++)
      if (idx < 0 && int'(expq[k].ch) == ch) idx = k;
    check("frame_pending_for_channel", (idx >= 0), 1'b1);
    obs_order.push_back(ch);
    if (idx >= 0) begin
      e = expq[idx];
      expq.delete(idx);
      check("frame_tag", mon_tag, {e.ch, e.utag});
      check("frame_niter", mon_niter, e.niter);
      check("frame_fmode", mon_fmode, e.fmode);
      check("frame_len", mon_n, FW);
      check("frame_words", mon_words, e.words);
    end
  endtask

  task automatic step();
    logic [NCH-1:0] acc;
    @(negedge clk);
    if ($countones(och_rdy) > 1) rdy_multi++;
    rdy_seen |= och_rdy;
    if (last_en && dif.dec_ival) begin
      if (dif.dec_isop) begin
        in_frame = 1'b1; mon_n = 0; mon_words = '0;
        mon_tag = dif.dec_itag; mon_niter = dif.dec_iNiter; mon_fmode = dif.dec_ifmode;
        isop_cnt++;
      end
      if (!in_frame) stray_cnt++;
      else begin
        if (mon_n < FW) mon_words[mon_n*WW +: WW] = dif.dec_iLLR;
        mon_n++;
        if (dif.dec_ieop) begin
          in_frame = 1'b0;
          check_frame();
        end
      end
    end
    acc = och_rdy & ich_val & {NCH{clkena}};
    @(posedge clk);
    last_en = clkena;
    #1;
    for (int ch = 0; ch < NCH; ch++)
      if (acc[ch] && srcq[ch].size() > 0) void'(srcq[ch].pop_front());
    drive();
  endtask

  function automatic bit src_empty();
    for (int ch = 0; ch < NCH; ch++)
      if (srcq[ch].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_until_done(input int max);
    int n = 0;
    while (!(src_empty() && expq.size() == 0) && n < max) begin
      step();
      n++;
    end
    check("drain_within_budget", (n < max), 1'b1);
    repeat (3) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"}, och_rdy, '0);
    check({tag, "_strobes"}, {dif.dec_isop, dif.dec_ival, dif.dec_ieop}, '0);
    check({tag, "_data"}, {dif.dec_iLLR, dif.dec_iNiter, dif.dec_ifmode, dif.dec_itag}, '0);
    check({tag, "_sticky"}, {ostat_pad, ostat_ovf}, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int isop_before, n, p;
    ich_sop = '0; ich_eop = '0; ich_val = '0; ich_fmode = '0;
    ich_LLR = '0; ich_niter = '0; ich_utag = '0;
    dif.dec_ordy = 1'b1; dif.dec_oval = 1'b0; dif.dec_oeop = 1'b0; dif.dec_otag = '0;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_hold");
    @(negedge clk) rst_n = 1'b1;
    step();
    check_all_zero("after_reset_idle");

    // All four channels requesting from pointer 0: grants follow 0,1,2,3,0
    obs_order.delete();
    rdy_multi = 0;
    add_frame(0, FW, 8'($urandom), 1'b0, 2'd0);
    add_frame(1, FW, 8'($urandom), 1'b1, 2'd1);
    add_frame(2, FW, 8'($urandom), 1'b0, 2'd2);
    add_frame(3, FW, 8'($urandom), 1'b1, 2'd3);
    add_frame(0, FW, 8'($urandom), 1'b1, 2'd2);
    drive();
    run_until_done(2000);
    check("rr_frame_count", obs_order.size(), 5);
    p = 0;
    for (int k = 0; k < 5 && k < obs_order.size(); k++) begin
      check("rr_order", obs_order[k], p);
      p = (p + 1) % NCH;
    end
    check("rr_rdy_onehot", rdy_multi, 0);

    // Single channel 2, niter 10, utag 1, exact-length frame
    rdy_seen = '0;
    isop_before = isop_cnt;
    add_frame(2, FW, 8'd10, 1'b0, 2'd1);
    drive();
    run_until_done(500);
    check("single_rdy_bits", rdy_seen, 4'b0100);
    check("single_isop_count", isop_cnt - isop_before, 1);
    check("single_rdy_after", och_rdy, '0);

    // Short frame on ch1 is zero-padded to full length
    add_frame(1, 20, 8'd7, 1'b1, 2'd2);
    add_frame(0, FW, 8'd3, 1'b0, 2'd0);
    drive();
    run_until_done(800);
    check("pad_sticky", ostat_pad, 4'b0010);

    // Long frame on ch3 is truncated and its tail swallowed
    add_frame(3, 40, 8'd12, 1'b0, 2'd3);
    drive();
    run_until_done(800);
    check("ovf_sticky", ostat_ovf, 4'b1000);
    check("ovf_pad_unchanged", ostat_pad, 4'b0010);

    // sop and eop on the same word
    add_frame(0, 1, 8'd5, 1'b1, 2'd1);
    drive();
    run_until_done(500);
    check("one_word_pad_sticky", ostat_pad, 4'b0011);

    // Decoder not ready: no grant for 50 cycles, then quick grant
    dif.dec_ordy = 1'b0;
    rdy_seen = '0;
    isop_before = isop_cnt;
    add_frame(0, FW, 8'd20, 1'b0, 2'd0);
    add_frame(2, FW, 8'd21, 1'b1, 2'd3);
    drive();
    repeat (50) step();
    check("ordy_low_no_isop", isop_cnt - isop_before, 0);
    check("ordy_low_no_rdy", rdy_seen, '0);
    dif.dec_ordy = 1'b1;
    n = 0;
    while (och_rdy == '0 && n < 4) begin
      step();
      n++;
    end
    check("ordy_grant_latency", (n <= 2), 1'b1);
    run_until_done(1000);

    // Clock enable low for 5 cycles in the middle of a frame
    add_frame(2, FW, 8'd33, 1'b1, 2'd2);
    drive();
    repeat (8) step();
    clkena = 1'b0;
    repeat (5) step();
    clkena = 1'b1;
    run_until_done(500);

    // Random traffic with random decoder readiness
    rand_ordy = 1'b1;
    for (int f = 0; f < 10; f++)
      add_frame($urandom_range(0, NCH - 1), $urandom_range(1, 40), 8'($urandom),
                1'($urandom), 2'($urandom));
    drive();
    run_until_done(6000);
    rand_ordy = 1'b0;
    dif.dec_ordy = 1'b1;
    check("random_pad_sticky", ostat_pad, exp_pad);
    check("random_ovf_sticky", ostat_ovf, exp_ovf);
    check("no_stray_words", stray_cnt, 0);
    check("rdy_onehot_overall", rdy_multi, 0);

    // Output demux by tag channel field
    for (int c = 0; c < NCH; c++) begin
      dif.dec_oval = 1'b1;
      dif.dec_oeop = (c % 2 == 1);
      dif.dec_otag = {2'(c), 2'($urandom)};
      #1;
      check("demux_oval", och_oval, 4'b0001 << c);
      check("demux_oeop", och_oeop, (c % 2 == 1) ? (4'b0001 << c) : 4'b0000);
    end
    dif.dec_oval = 1'b0; dif.dec_oeop = 1'b0;
    #1 check("demux_idle", {och_oval, och_oeop}, '0);

    // Reset in the middle of a ch1 frame, then pointer must restart at 0
    add_frame(1, FW, 8'd9, 1'b0, 2'd1);
    drive();
    repeat (10) step();
    #2 rst_n = 1'b0;
    #1 check_all_zero("midframe_reset");
    for (int ch = 0; ch < NCH; ch++) srcq[ch].delete();
    expq.delete();
    in_frame = 1'b0;
    exp_pad = '0; exp_ovf = '0;
    drive();
    @(negedge clk) rst_n = 1'b1;
    obs_order.delete();
    add_frame(1, FW, 8'd1, 1'b0, 2'd0);
    add_frame(3, FW, 8'd2, 1'b1, 2'd1);
    drive();
    run_until_done(1000);
    check("post_reset_frames", obs_order.size(), 2);
    if (obs_order.size() == 2) begin
      check("post_reset_first", obs_order[0], 1);
      check("post_reset_second", obs_order[1], 3);
    end
    check("post_reset_sticky", {ostat_pad, ostat_ovf}, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
